// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch stage types and constants
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam int unsigned PC_RESET_VALUE = 0;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with decoder handshake
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int bit_width = 32,
    parameter int pc_step   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [bit_width-1:0] pc_in,
    output logic [bit_width-1:0] pc_next,
    output logic                 mem_req,
    output logic [bit_width-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [bit_width-1:0] mem_rdata,
    output logic [bit_width-1:0] instr,
    output logic [bit_width-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    input  logic                 flush
);

    fetch_state_t         state_q, state_d;
    logic [bit_width-1:0] addr_q, addr_d;
    logic [bit_width-1:0] instr_q, instr_d;
    logic [bit_width-1:0] instr_pc_q, instr_pc_d;
    logic                 mem_req_q, mem_req_d;
    logic                 instr_valid_q, instr_valid_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A flush in WAIT cannot withdraw the request, so it parks in DRAIN until the ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = ISSUE;
            ISSUE: state_d = flush ? ISSUE : WAIT;
            WAIT: begin
                if (flush) begin
                    state_d = mem_ack ? ISSUE : DRAIN;
                end else if (mem_ack) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush || instr_ready) begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (mem_ack) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_next       = pc_in;
        addr_d        = addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        mem_req_d     = (state_d == WAIT) || (state_d == DRAIN);
        instr_valid_d = (state_d == HOLD);
        if (state_q == HOLD && instr_ready && !flush) begin
            pc_next = pc_in + bit_width'(pc_step);
        end
        if (state_q == ISSUE && !flush) begin
            addr_d = pc_in;
        end
        if (state_q == WAIT && mem_ack && !flush) begin
            instr_d    = mem_rdata;
            instr_pc_d = addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q        <= bit_width'(PC_RESET_VALUE);
            instr_q       <= '0;
            instr_pc_q    <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            mem_req_q     <= mem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a register file PC model
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_next;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    logic        rf_reset = 1'b1;
    logic        rf_write = 1'b0;
    logic [31:0] rf_target = '0;
    logic [31:0] rf_pc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Register file PC: cleared by its own reset, overwritten by jumps, else takes pc_next.
    always @(posedge clk) begin
        if (rf_reset)      rf_pc <= '0;
        else if (rf_write) rf_pc <= rf_target;
        else               rf_pc <= pc_next;
    end

    fetch_unit #(.bit_width(32), .pc_step(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (rf_pc),
        .pc_next     (pc_next),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flush       (rf_write)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        // Reset state
        check("rst_req",   {31'd0, mem_req}, 32'd0);
        check("rst_addr",  mem_addr, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_ipc",   instr_pc, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_pcnext", pc_next, 32'd0);
        reset = 1'b0;
        rf_reset = 1'b0;

        // First fetch: ISSUE, then WAIT, ack on the third WAIT cycle
        tick();
        check("t1_issue_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("t1_wait_req",  {31'd0, mem_req}, 32'd1);
        check("t1_wait_addr", mem_addr, 32'd0);
        tick();
        check("t1_wait2_val", {31'd0, instr_valid}, 32'd0);
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'hA5A5_0001;
        #1;
        check("t1_ack_val", {31'd0, instr_valid}, 32'd0);
        tick();
        mem_ack = 1'b0;
        mem_rdata = '0;
        check("t1_hold_val",   {31'd0, instr_valid}, 32'd1);
        check("t1_hold_instr", instr, 32'hA5A5_0001);
        check("t1_hold_ipc",   instr_pc, 32'd0);

        // Decoder stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t2_val",    {31'd0, instr_valid}, 32'd1);
            check("t2_instr",  instr, 32'hA5A5_0001);
            check("t2_pcnext", pc_next, 32'd0);
            check("t2_req",    {31'd0, mem_req}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        #1;
        check("t2_accept_pcnext", pc_next, 32'd1);
        tick();
        instr_ready = 1'b0;
        check("t2_issue_val", {31'd0, instr_valid}, 32'd0);
        check("t2_issue_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("t2_wait_addr", mem_addr, 32'd1);
        check("t2_wait_req",  {31'd0, mem_req}, 32'd1);

        // Flush in WAIT without ack, ack 3 cycles later is discarded
        rf_write = 1'b1;
        rf_target = 32'h40;
        #1;
        check("t3_flush_pcnext", pc_next, 32'd1);
        tick();
        rf_write = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t3_drain_req",  {31'd0, mem_req}, 32'd1);
            check("t3_drain_addr", mem_addr, 32'd1);
            check("t3_drain_val",  {31'd0, instr_valid}, 32'd0);
            tick();
        end
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        check("t3_ack_req", {31'd0, mem_req}, 32'd1);
        tick();
        mem_ack = 1'b0;
        check("t3_post_val",   {31'd0, instr_valid}, 32'd0);
        check("t3_post_instr", instr, 32'hA5A5_0001);
        tick();
        check("t3_refetch_addr", mem_addr, 32'h40);
        check("t3_refetch_val",  {31'd0, instr_valid}, 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_0040;
        tick();
        mem_ack = 1'b0;
        check("t3_hold_val",   {31'd0, instr_valid}, 32'd1);
        check("t3_hold_instr", instr, 32'h1111_0040);
        check("t3_hold_ipc",   instr_pc, 32'h40);

        // Flush together with instr_ready in HOLD: no increment
        instr_ready = 1'b1;
        rf_write = 1'b1;
        rf_target = 32'h80;
        #1;
        check("t4_pcnext", pc_next, 32'h40);
        tick();
        instr_ready = 1'b0;
        rf_write = 1'b0;
        check("t4_issue_val", {31'd0, instr_valid}, 32'd0);
        tick();
        check("t4_wait_addr", mem_addr, 32'h80);

        // Flush in WAIT coinciding with ack: data dropped, straight to ISSUE
        rf_write = 1'b1;
        rf_target = 32'hFFFF_FFFF;
        mem_ack = 1'b1;
        mem_rdata = 32'h2222_2222;
        tick();
        rf_write = 1'b0;
        mem_ack = 1'b0;
        check("t5_issue_val", {31'd0, instr_valid}, 32'd0);
        check("t5_issue_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("t5_wait_addr", mem_addr, 32'hFFFF_FFFF);
        mem_ack = 1'b1;
        mem_rdata = 32'h3333_3333;
        tick();
        mem_ack = 1'b0;
        check("t5_hold_instr", instr, 32'h3333_3333);
        check("t5_hold_ipc",   instr_pc, 32'hFFFF_FFFF);
        instr_ready = 1'b1;
        #1;
        check("t5_wrap_pcnext", pc_next, 32'h0);
        tick();
        instr_ready = 1'b0;
        tick();
        check("t5_wrap_addr", mem_addr, 32'h0);
        check("t5_wrap_req",  {31'd0, mem_req}, 32'd1);

        // Reset mid-WAIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_req",   {31'd0, mem_req}, 32'd0);
        check("t6_val",   {31'd0, instr_valid}, 32'd0);
        check("t6_state", 32'(dut.state_q), 32'(IDLE));
        tick();
        check("t6_issue_req", {31'd0, mem_req}, 32'd0);
        tick();
        check("t6_wait_req", {31'd0, mem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
